// File: rtl/strobe_word_collector.sv
// Collects bits captured by an asynchronous strobe into W-bit words behind a 2-entry skid FIFO.
// Optional macro STROBE_WORD_COLLECTOR_PARITY_EN adds the even-parity output o4.
module strobe_word_collector #(
  parameter int W    = 8,
  parameter int SYNC = 2
) (
  input  logic         i1,
  input  logic         i2,
  input  logic         i3,
  input  logic         i4,
  input  logic         i5,
  output logic [W-1:0] o1,
  output logic         o2,
  output logic         o3
`ifdef STROBE_WORD_COLLECTOR_PARITY_EN
  ,
  output logic         o4
`endif
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
`ifdef STROBE_WORD_COLLECTOR_PARITY_EN
  localparam int EW = W + 1;
`else
  localparam int EW = W;
`endif

  logic [SYNC-1:0] strb_sync_p0;
  logic [SYNC-1:0] data_sync_p0;
  logic            strb_prev_p1;
  logic            strb_s;
  logic            data_s;
  logic            ev;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    shreg;
  logic [W-1:0]    word_new;
  logic [EW-1:0]   entry_new;
  logic            push;
  logic            pop;

  logic [EW-1:0]   head, head_nxt;
  logic [EW-1:0]   tail, tail_nxt;
  logic [1:0]      occ, occ_nxt;
  logic            ovf, ovf_nxt;

  // Stage 0: synchronizers for strobe and data, equal depth so they stay aligned
  always_ff @(posedge i1 or negedge i2) begin
    if (!i2) begin
      strb_sync_p0 <= '0;
      data_sync_p0 <= '0;
      strb_prev_p1 <= 1'b0;
    end else begin
      strb_sync_p0 <= {strb_sync_p0[SYNC-2:0], i4};
      data_sync_p0 <= {data_sync_p0[SYNC-2:0], i3};
      strb_prev_p1 <= strb_sync_p0[SYNC-1];
    end
  end

  assign strb_s = strb_sync_p0[SYNC-1];
  assign data_s = data_sync_p0[SYNC-1];
  assign ev     = strb_s & ~strb_prev_p1;
  assign push   = ev && (cnt == LAST);
  assign pop    = o2 && i5;

  always_comb begin
    word_new      = shreg;
    word_new[cnt] = data_s;
  end

`ifdef STROBE_WORD_COLLECTOR_PARITY_EN
  assign entry_new = {^word_new, word_new};
`else
  assign entry_new = word_new;
`endif

  // Stage 1: word assembly
  always_ff @(posedge i1 or negedge i2) begin
    if (!i2) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (ev) begin
      shreg <= word_new;
      cnt   <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Stage 2: skid FIFO; a push meeting a pop always lands behind the surviving entry
  always_comb begin
    head_nxt = head;
    tail_nxt = tail;
    occ_nxt  = occ;
    ovf_nxt  = ovf;
    case ({push, pop})
      2'b11: begin
        if (occ == 2'd2) begin
          head_nxt = tail;
          tail_nxt = entry_new;
        end else begin
          head_nxt = entry_new;
        end
      end
      2'b10: begin
        if (occ == 2'd0) begin
          head_nxt = entry_new;
          occ_nxt  = 2'd1;
        end else if (occ == 2'd1) begin
          tail_nxt = entry_new;
          occ_nxt  = 2'd2;
        end else begin
          ovf_nxt  = 1'b1;
        end
      end
      2'b01: begin
        if (occ == 2'd2) head_nxt = tail;
        occ_nxt = occ - 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i1 or negedge i2) begin
    if (!i2) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
      ovf  <= 1'b0;
    end else begin
      head <= head_nxt;
      tail <= tail_nxt;
      occ  <= occ_nxt;
      ovf  <= ovf_nxt;
    end
  end

  assign o1 = head[W-1:0];
  assign o2 = (occ != 2'd0);
  assign o3 = ovf;
`ifdef STROBE_WORD_COLLECTOR_PARITY_EN
  assign o4 = head[W] & o2;
`endif

endmodule
